spi_top: RTL and testbench
==========================

SPI_TOP -- requirements
Module: spi_top

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the transfer length in bits.
REQ-002 Parameter CLK_DIV, default 2, SHALL set the sclk half-period in clk cycles (minimum 1).
REQ-003 clk  input  1  sole clock; all logic SHALL use its rising edge.
REQ-004 rst  input  1  reset, SHALL be asynchronous and active-low.
REQ-005 start  input  1  transfer request, sampled only in IDLE.
REQ-006 master_data_in  input  DATA_WIDTH  byte the master transmits on mosi.
REQ-007 slave1_data_in  input  DATA_WIDTH  byte slave 1 returns on miso.
REQ-008 slave2_data_in  input  DATA_WIDTH  byte slave 2 returns on miso.
REQ-009 slave_select  input  1  target slave: 0 = slave 1, 1 = slave 2.
REQ-010 sclk  output  1  serial clock, idle low (SPI mode 0).
REQ-011 mosi  output  1  master serial out, MSB first.
REQ-012 miso  output  1  serial out of the selected slave; high-Z when no cs asserted; the master SHALL sample this same net.
REQ-013 cs  output  2  active-low chip selects: cs[0] = slave 1, cs[1] = slave 2.
REQ-014 master_data_out  output  DATA_WIDTH  byte the master received.
REQ-015 slave1_data_out / slave2_data_out  output  DATA_WIDTH  byte each slave last received.
REQ-016 done  output  1  one-cycle pulse at transfer completion.

Function
REQ-017 FSM SHALL have states IDLE, TRANSFER, DONE.
REQ-018 IDLE: sclk=0, cs=2'b11, mosi=0, done=0; start=1 SHALL latch master_data_in, both slaveN_data_in and slave_select, drive cs low for the selected slave only, put the MSB on mosi and on miso, then enter TRANSFER.
REQ-019 TRANSFER: sclk SHALL toggle every CLK_DIV clk cycles.
REQ-020 On each sclk rising edge, the master SHALL shift in miso and the selected slave SHALL shift in mosi.
REQ-021 On each sclk falling edge, the next bit SHALL be presented on mosi/miso.
REQ-022 After DATA_WIDTH rising edges and the final falling edge (sclk low), the FSM SHALL enter DONE.
REQ-023 DONE: cs SHALL return to 2'b11 and done SHALL be 1 for exactly one cycle.
REQ-024 In DONE, master_data_out and only the selected slaveN_data_out SHALL update; the unselected output SHALL hold its value.
REQ-025 The FSM SHALL then return to IDLE.
REQ-026 Latency: done SHALL assert 2*DATA_WIDTH*CLK_DIV+1 clk cycles after the cycle start is sampled (33 at defaults).
REQ-027 start while in TRANSFER or DONE SHALL be ignored.
REQ-028 Input data and slave_select changes during a transfer SHALL have no effect.
REQ-029 start held high SHALL begin a new transfer on the first IDLE cycle after DONE.
REQ-030 Exactly one cs bit SHALL be low during TRANSFER; cs SHALL never be 2'b00.

Reset
REQ-031 rst low SHALL force, immediately and at any point including mid-transfer: IDLE, sclk=0, mosi=0, cs=2'b11, miso high-Z, done=0, all data outputs 0, all shift registers and counters 0.
REQ-032 A transfer interrupted by reset SHALL be discarded, with no partial output update.

Structure
REQ-033 Package spi_pkg SHALL hold the FSM state enum and the DATA_WIDTH/CLK_DIV defaults.
REQ-034 Sub-module spi_slave (shift register, chip-select gating, received-byte output) SHALL be instantiated twice.
REQ-035 Master shift logic, the clock divider, the FSM and the miso mux SHALL live in spi_top.
REQ-036 Target size is 120-400 lines of RTL.

Verification
REQ-037 Reset: rst low mid-transfer -> cs=2'b11, sclk=0, done=0, all data outputs 0 in the same cycle.
REQ-038 Slave 1: master 0xA5, slave1 0x5A, slave_select=0, start pulse -> cs=2'b10, 8 sclk pulses, done after 33 cycles, master_data_out=0x5A, slave1_data_out=0xA5, slave2_data_out unchanged.
REQ-039 Slave 2: master 0xA5, slave2 0xC3, slave_select=1 -> cs=2'b01, master_data_out=0xC3, slave2_data_out=0xA5, slave1_data_out keeps 0xA5.
REQ-040 Busy: start re-pulsed and slave_select flipped mid-transfer -> no restart, cs unchanged, single done pulse.
REQ-041 Bit order: master 0x80 -> mosi high only during the first bit period; slave captures 0x80.
REQ-042 Back-to-back: start held high -> a second transfer begins the cycle after DONE, two done pulses 34 cycles apart.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and default transfer geometry.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRANSFER = 2'd1,
    DONE     = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CLK_DIV    = 2;

endpackage : spi_pkg

// File: rtl/spi_slave.sv
// SPI mode-0 slave: shifts in mosi on sclk rise, presents next miso bit on sclk fall,
// and publishes the received word only when the master closes a transfer addressed to it.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  cs_n,
  input  logic                  sclk_rise,
  input  logic                  sclk_fall,
  input  logic                  capture,
  input  logic                  mosi,
  output logic                  miso,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;

  assign miso = tx_shift[DATA_WIDTH-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_shift <= '0;
      rx_shift <= '0;
      data_out <= '0;
    end else if (load) begin
      tx_shift <= tx_data;
      rx_shift <= '0;
    end else if (!cs_n) begin
      if (sclk_rise) rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi};
      if (sclk_fall) tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
      if (capture)   data_out <= rx_shift;
    end
  end

endmodule : spi_slave

// File: rtl/spi_top.sv
// SPI mode-0 master with two on-chip slaves sharing one tri-stated miso net.
// Clock divider, FSM, master shift registers and the miso mux live here.
module spi_top
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CLK_DIV    = DEF_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] master_data_in,
  input  logic [DATA_WIDTH-1:0] slave1_data_in,
  input  logic [DATA_WIDTH-1:0] slave2_data_in,
  input  logic                  slave_select,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  miso,
  output logic [1:0]            cs,
  output logic [DATA_WIDTH-1:0] master_data_out,
  output logic [DATA_WIDTH-1:0] slave1_data_out,
  output logic [DATA_WIDTH-1:0] slave2_data_out,
  output logic                  done
);

  localparam int DIV_W = (CLK_DIV > 1)    ? $clog2(CLK_DIV)    : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                state, next_state;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] tx_shift, rx_shift;
  logic                  load, tick, sclk_rise, sclk_fall, last_fall;
  logic                  s1_miso, s2_miso;

  assign tick      = (state == TRANSFER) && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign sclk_rise = tick && !sclk;
  assign sclk_fall = tick && sclk;
  // The last falling edge closes the transfer; cs and outputs update on that same edge.
  assign last_fall = sclk_fall && (bit_cnt == BIT_W'(DATA_WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (start)     next_state = TRANSFER;
      TRANSFER: if (last_fall) next_state = DONE;
      DONE:                    next_state = IDLE;
      default:                 next_state = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    load = 1'b0;
    mosi = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE:     load = start;
      TRANSFER: mosi = tx_shift[DATA_WIDTH-1];
      DONE:     done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
    end else if (state != TRANSFER) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      sclk    <= !sclk;
      if (sclk_fall) bit_cnt <= bit_cnt + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_shift        <= '0;
      rx_shift        <= '0;
      cs              <= 2'b11;
      master_data_out <= '0;
    end else if (load) begin
      tx_shift <= master_data_in;
      rx_shift <= '0;
      cs       <= slave_select ? 2'b01 : 2'b10;
    end else begin
      if (sclk_rise) rx_shift <= {rx_shift[DATA_WIDTH-2:0], miso};
      if (sclk_fall) tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
      if (last_fall) begin
        cs              <= 2'b11;
        master_data_out <= rx_shift;
      end
    end
  end

  // Shared miso net: only the slave whose cs is low drives it; the master reads it back.
  assign miso = !cs[0] ? s1_miso : (!cs[1] ? s2_miso : 1'bz);

  spi_slave #(.DATA_WIDTH(DATA_WIDTH)) u_slave1 (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .tx_data   (slave1_data_in),
    .cs_n      (cs[0]),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .capture   (last_fall),
    .mosi      (mosi),
    .miso      (s1_miso),
    .data_out  (slave1_data_out)
  );

  spi_slave #(.DATA_WIDTH(DATA_WIDTH)) u_slave2 (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .tx_data   (slave2_data_in),
    .cs_n      (cs[1]),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .capture   (last_fall),
    .mosi      (mosi),
    .miso      (s2_miso),
    .data_out  (slave2_data_out)
  );

endmodule : spi_top

// File: tb/tb_spi_top.sv
// Self-checking bench for spi_top: directed vector table, multi-cycle corner sequences,
// and randomized transfers against a word-level reference model.
module tb_spi_top;

  localparam int W       = 8;
  localparam int DIV     = 2;
  localparam int LATENCY = 2 * W * DIV + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] master_data_in, slave1_data_in, slave2_data_in;
  logic         slave_select;
  wire          sclk, mosi, miso, done;
  wire  [1:0]   cs;
  wire  [W-1:0] master_data_out, slave1_data_out, slave2_data_out;

  spi_top #(.DATA_WIDTH(W), .CLK_DIV(DIV)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .master_data_in  (master_data_in),
    .slave1_data_in  (slave1_data_in),
    .slave2_data_in  (slave2_data_in),
    .slave_select    (slave_select),
    .sclk            (sclk),
    .mosi            (mosi),
    .miso            (miso),
    .cs              (cs),
    .master_data_out (master_data_out),
    .slave1_data_out (slave1_data_out),
    .slave2_data_out (slave2_data_out),
    .done            (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int cycle_cnt = 0;
  int last_done_cycle = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Word-level reference model: what each output register should hold.
  logic [W-1:0] exp_m, exp_s1, exp_s2;

  typedef struct {
    logic [W-1:0] m, s1, s2;
    logic         sel;
    logic [W-1:0] em, es1, es2;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_master_out"}, 32'(master_data_out), 32'(exp_m));
    check({tag, "_slave1_out"}, 32'(slave1_data_out), 32'(exp_s1));
    check({tag, "_slave2_out"}, 32'(slave2_data_out), 32'(exp_s2));
  endtask

  // Entered and left on a negedge. Observes the serial lines bit by bit and
  // updates the model from the values present when start was accepted.
  task automatic run_transfer(input logic [W-1:0] m, s1, s2, input logic sel,
                              input bit disturb, input bit hold);
    int           cyc = 0;
    int           rises = 0;
    int           cs_bad = 0;
    bit           seen = 0;
    logic         prev_sclk;
    logic [W-1:0] mosi_bits = '0;
    logic [W-1:0] miso_bits = '0;
    logic [1:0]   exp_cs;
    master_data_in = m;
    slave1_data_in = s1;
    slave2_data_in = s2;
    slave_select   = sel;
    start          = 1'b1;
    exp_cs         = sel ? 2'b01 : 2'b10;
    prev_sclk      = sclk;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && !hold) start = 1'b0;
      if (disturb && cyc == 10) begin
        start          = 1'b1;
        slave_select   = ~sel;
        master_data_in = W'($urandom);
        slave1_data_in = W'($urandom);
        slave2_data_in = W'($urandom);
      end
      if (disturb && cyc == 12 && !hold) start = 1'b0;
      if (done) begin
        seen = 1;
        last_done_cycle = cycle_cnt;
      end else begin
        if (cs !== exp_cs) cs_bad++;
        if (sclk && !prev_sclk) begin
          rises++;
          mosi_bits = {mosi_bits[W-2:0], mosi};
          miso_bits = {miso_bits[W-2:0], miso};
        end
      end
      prev_sclk = sclk;
    end
    check("done_latency", 32'(cyc), 32'(LATENCY));
    check("sclk_pulses", 32'(rises), 32'(W));
    check("cs_during_transfer", 32'(cs_bad), 32'd0);
    check("cs_at_done", 32'(cs), 32'h3);
    check("mosi_bits", 32'(mosi_bits), 32'(m));
    check("miso_bits", 32'(miso_bits), 32'(sel ? s2 : s1));
    exp_m = sel ? s2 : s1;
    if (sel) exp_s2 = m;
    else     exp_s1 = m;
    @(negedge clk);
    check("done_width", 32'(done), 32'd0);
  endtask

  vec_t vecs[4];
  int   d1, extra;

  initial begin
    vecs[0] = '{m: 8'hA5, s1: 8'h5A, s2: 8'h33, sel: 1'b0, em: 8'h5A, es1: 8'hA5, es2: 8'h00};
    vecs[1] = '{m: 8'hA5, s1: 8'h11, s2: 8'hC3, sel: 1'b1, em: 8'hC3, es1: 8'hA5, es2: 8'hA5};
    vecs[2] = '{m: 8'h80, s1: 8'hFF, s2: 8'h00, sel: 1'b0, em: 8'hFF, es1: 8'h80, es2: 8'hA5};
    vecs[3] = '{m: 8'h3C, s1: 8'h00, s2: 8'h7E, sel: 1'b1, em: 8'h7E, es1: 8'h80, es2: 8'h3C};

    rst = 1'b0;
    start = 1'b0;
    master_data_in = '0;
    slave1_data_in = '0;
    slave2_data_in = '0;
    slave_select = 1'b0;
    exp_m = '0;
    exp_s1 = '0;
    exp_s2 = '0;
    repeat (3) @(negedge clk);
    check("reset_cs", 32'(cs), 32'h3);
    check("reset_sclk", 32'(sclk), 32'd0);
    check("reset_mosi", 32'(mosi), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check_outputs("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed vectors.
    foreach (vecs[i]) begin
      run_transfer(vecs[i].m, vecs[i].s1, vecs[i].s2, vecs[i].sel, 1'b0, 1'b0);
      check($sformatf("vec%0d_master_out", i), 32'(master_data_out), 32'(vecs[i].em));
      check($sformatf("vec%0d_slave1_out", i), 32'(slave1_data_out), 32'(vecs[i].es1));
      check($sformatf("vec%0d_slave2_out", i), 32'(slave2_data_out), 32'(vecs[i].es2));
      repeat (2) @(negedge clk);
    end

    // Busy: start re-pulsed and select flipped mid-transfer.
    run_transfer(8'h96, 8'h4D, 8'hE1, 1'b0, 1'b1, 1'b0);
    check_outputs("busy");
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("busy_single_done", 32'(extra), 32'd0);

    // Back-to-back with start held high.
    run_transfer(8'h12, 8'h34, 8'h56, 1'b1, 1'b0, 1'b1);
    d1 = last_done_cycle;
    run_transfer(8'hCA, 8'hFE, 8'hBA, 1'b0, 1'b0, 1'b0);
    check("b2b_done_spacing", 32'(last_done_cycle - d1), 32'(LATENCY + 1));
    check_outputs("b2b");
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-transfer: immediate clear, no partial update afterwards.
    master_data_in = 8'h5F;
    slave1_data_in = 8'h9C;
    slave_select   = 1'b0;
    start          = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    exp_m = '0;
    exp_s1 = '0;
    exp_s2 = '0;
    check("midrst_cs", 32'(cs), 32'h3);
    check("midrst_sclk", 32'(sclk), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check_outputs("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || cs != 2'b11) extra++;
    end
    check("midrst_no_resume", 32'(extra), 32'd0);
    check_outputs("midrst_after");

    // Randomized transfers against the model.
    for (int n = 0; n < 20; n++) begin
      run_transfer(W'($urandom), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 1)), 1'b0);
      check_outputs($sformatf("rand%0d", n));
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_spi_top
